// File: rtl/tile_pkg.sv
// Shared tile definitions: FSM states, tile geometry, ROM addressing.
// Reused by tile_map_scheduler and tile_drawer.
package tile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_FINISH
  } state_e;

  localparam int TILE_PX        = 8;
  localparam int WORDS_PER_TILE = 64;

  localparam logic [7:0] EMPTY_TILE_DEF = 8'hFF;

  // First ROM word of a tile; 64 words per tile, 16-bit wrap
  function automatic logic [15:0] tile_rom_addr(
    input logic [15:0] base,
    input logic [7:0]  idx
  );
    return base + {2'b00, idx, 6'b000000};
  endfunction

endpackage

// File: rtl/tile_map_scheduler_if.sv
// Scheduler bus: frame request, map RAM read port, drawer launch.
// master = scheduler side, slave = environment side.
interface tile_map_scheduler_if;

  logic        start;
  logic [8:0]  map_rd_addr;
  logic [7:0]  map_rd_data;
  logic        draw;
  logic [15:0] tile_address;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        drawer_done;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start,
    input  map_rd_data,
    input  drawer_done,
    output map_rd_addr,
    output draw,
    output tile_address,
    output x_out,
    output y_out,
    output busy,
    output frame_done
  );

  modport slave (
    output start,
    output map_rd_data,
    output drawer_done,
    input  map_rd_addr,
    input  draw,
    input  tile_address,
    input  x_out,
    input  y_out,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/tile_grid_counter.sv
// Column/row walker over the tile map with linear map address.
// Holds at the last tile; clear restarts at tile 0.
module tile_grid_counter #(
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int CW   = 5,
  parameter int RW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          clear_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic [8:0]    addr_o,
  output logic          last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [8:0]    addr_q, addr_d;
  logic          col_last;
  logic          last;

  assign col_last = (col_q == CW'(COLS - 1));
  assign last     = col_last && (row_q == RW'(ROWS - 1));

  // Step to the next tile in raster order, never past the last one
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (inc_i && !last) begin
      addr_d = addr_q + 9'd1;
      if (col_last) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;
  assign last_o = last;

endmodule

// File: rtl/tile_map_scheduler.sv
// Walks the tile map once per start and launches tile_drawer
// for every non-empty tile; all outputs come from registers.
module tile_map_scheduler
  import tile_pkg::*;
#(
  parameter int          MAP_COLS   = 20,
  parameter int          MAP_ROWS   = 15,
  parameter logic [15:0] TILE_BASE  = 16'h0000,
  parameter logic [7:0]  EMPTY_TILE = EMPTY_TILE_DEF
) (
  input logic                  clk,
  input logic                  reset,
  tile_map_scheduler_if.master bus
);

  localparam int CW = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int RW = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;

  state_e state_q, state_d;

  logic [7:0]  tile_idx_q, tile_idx_d;
  logic [15:0] tile_addr_q, tile_addr_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        draw_q, draw_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;

  logic [CW-1:0] col_w;
  logic [RW-1:0] row_w;
  logic [8:0]    addr_w;
  logic          last_w;
  logic          grid_inc;
  logic          grid_clr;

  assign grid_clr = (state_q == ST_IDLE) && bus.start;
  assign grid_inc = (state_q == ST_ADVANCE) && !last_w;

  tile_grid_counter #(
    .COLS (MAP_COLS),
    .ROWS (MAP_ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_grid (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (grid_inc),
    .clear_i (grid_clr),
    .col_o   (col_w),
    .row_o   (row_w),
    .addr_o  (addr_w),
    .last_o  (last_w)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; drawer_done only matters in WAIT_DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.start) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_READ;
      ST_READ:      state_d = ST_LAUNCH;
      ST_LAUNCH:    state_d = (tile_idx_q == EMPTY_TILE) ?
                              ST_ADVANCE : ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.drawer_done) state_d = ST_ADVANCE;
      ST_ADVANCE:   state_d = last_w ? ST_FINISH : ST_FETCH;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output next values; tile data is captured on READ->LAUNCH
  always_comb begin
    tile_idx_d  = tile_idx_q;
    tile_addr_d = tile_addr_q;
    x_d         = x_q;
    y_d         = y_q;
    if (state_q == ST_READ) begin
      tile_idx_d  = bus.map_rd_data;
      tile_addr_d = tile_rom_addr(TILE_BASE, bus.map_rd_data);
      x_d         = 8'(int'(col_w) * TILE_PX);
      y_d         = 8'(int'(row_w) * TILE_PX);
    end
    draw_d  = (state_q == ST_READ) &&
              (bus.map_rd_data != EMPTY_TILE);
    busy_d  = (state_d != ST_IDLE);
    fdone_d = (state_d == ST_FINISH);
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_idx_q  <= 8'h00;
      tile_addr_q <= TILE_BASE;
      x_q         <= 8'h00;
      y_q         <= 8'h00;
      draw_q      <= 1'b0;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
    end else begin
      tile_idx_q  <= tile_idx_d;
      tile_addr_q <= tile_addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      draw_q      <= draw_d;
      busy_q      <= busy_d;
      fdone_q     <= fdone_d;
    end
  end

  assign bus.map_rd_addr  = addr_w;
  assign bus.draw         = draw_q;
  assign bus.tile_address = tile_addr_q;
  assign bus.x_out        = x_q;
  assign bus.y_out        = y_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = fdone_q;

endmodule

// File: doc/tile_map_scheduler.md
TILE_MAP_SCHEDULER -- requirements
Module: tile_map_scheduler

Interface
REQ-001 SHALL have parameter MAP_COLS, default 20, tiles per row (160 px / 8).
REQ-002 SHALL have parameter MAP_ROWS, default 15, tile rows (120 px / 8).
REQ-003 SHALL have parameter TILE_BASE, default 16'h0000, ROM base address of tile 0.
REQ-004 SHALL have parameter EMPTY_TILE, default 8'hFF, map index meaning "skip, draw nothing".
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to draw one full frame.
REQ-008 SHALL have port map_rd_addr, output, 9, tile-map RAM read address (row*MAP_COLS+col).
REQ-009 SHALL have port map_rd_data, input, 8, tile index; valid one cycle after map_rd_addr.
REQ-010 SHALL have port draw, output, 1, one-cycle launch pulse to tile_drawer.
REQ-011 SHALL have port tile_address, output, 16, first ROM word of the tile to draw.
REQ-012 SHALL have port x_out / y_out, output, 8 each, top-left pixel of the tile.
REQ-013 SHALL have port drawer_done, input, 1, tile_drawer completion pulse.
REQ-014 SHALL have ports busy (output, 1) and frame_done (output, 1, one-cycle pulse).

Function
REQ-015 SHALL implement states IDLE, FETCH, READ, LAUNCH, WAIT_DONE, ADVANCE, FINISH.
REQ-016 IDLE: start=1 -> FETCH with col=0, row=0, map_rd_addr=0; start otherwise ignored.
REQ-017 FETCH: map_rd_addr held; -> READ. READ: register map_rd_data into tile_idx; -> LAUNCH.
REQ-018 LAUNCH: if tile_idx==EMPTY_TILE -> ADVANCE with draw=0; else draw=1 for exactly this cycle, -> WAIT_DONE.
REQ-019 tile_address SHALL equal TILE_BASE + {tile_idx, 6'b0} (64 words/tile), 16-bit wrap, registered on READ->LAUNCH.
REQ-020 x_out = col*8, y_out = row*8, 8-bit; tile_address, x_out, y_out SHALL be stable from LAUNCH until leaving WAIT_DONE.
REQ-021 WAIT_DONE: drawer_done=1 -> ADVANCE; else remain; drawer_done in any other state SHALL be ignored.
REQ-022 ADVANCE: col<MAP_COLS-1 -> col+1; else col=0, row+1; map_rd_addr increments by 1; -> FETCH.
REQ-023 ADVANCE at col=MAP_COLS-1, row=MAP_ROWS-1 -> FINISH; map_rd_addr not incremented past 299.
REQ-024 FINISH: frame_done=1 for one cycle; -> IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored (no restart, no queue).
REQ-026 start asserted in the FINISH cycle SHALL be ignored; a new frame needs start in IDLE.

Reset
REQ-027 reset=1 SHALL immediately force IDLE; draw=0, busy=0, frame_done=0, map_rd_addr=0, tile_address=TILE_BASE, x_out=0, y_out=0, col=row=0.
REQ-028 Reset mid-frame (any state incl. WAIT_DONE) SHALL abandon the frame without frame_done; first post-reset start restarts at tile 0.

Structure
REQ-029 State encodings, tile size (8), words-per-tile (64) and EMPTY_TILE default SHALL live in shared package tile_pkg, reused by tile_drawer.
REQ-030 col/row/map-address stepping SHALL be one sub-module tile_grid_counter (inc, clear, last outputs).
REQ-031 All outputs SHALL be registered; no combinational path from drawer_done or map_rd_data to any output.

Verification
REQ-032 Map all 8'h00, drawer model done 70 cycles after draw -> 300 draw pulses, last at x=152,y=112, then one frame_done.
REQ-033 Map[0]=8'h03, Map[21]=8'h10 -> tile_address 16'h00C0 at (0,0); 16'h0400 at (8,8).
REQ-034 Map[5]=EMPTY_TILE, rest 0 -> 299 draw pulses; no draw with x_out=40,y_out=0.
REQ-035 start pulsed again at tile 10 and in FINISH cycle -> no restart, exactly one frame_done, busy falls after it.
REQ-036 reset asserted during WAIT_DONE of tile 50 -> outputs at reset values same cycle, no frame_done; new start draws tile 0 first.
REQ-037 drawer_done pulsed spuriously in IDLE and READ -> no state change, no skipped tile.
